// File: rtl/md_unit_pkg.sv
// Shared encodings and sizing helpers for the multiply/divide unit.
package md_unit_pkg;

    localparam int unsigned OP_W = 3;

    localparam logic [OP_W-1:0] MD_MULT  = 3'd0;
    localparam logic [OP_W-1:0] MD_MULTU = 3'd1;
    localparam logic [OP_W-1:0] MD_DIV   = 3'd2;
    localparam logic [OP_W-1:0] MD_DIVU  = 3'd3;
    localparam logic [OP_W-1:0] MD_MTHI  = 3'd4;
    localparam logic [OP_W-1:0] MD_MTLO  = 3'd5;

    // Counter must hold the longer of the two latencies.
    function automatic int unsigned md_cnt_width(input int unsigned mult_cycles,
                                                 input int unsigned div_cycles);
        int unsigned max_cycles;
        max_cycles = (mult_cycles > div_cycles) ? mult_cycles : div_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/md_unit_if.sv
// EX-stage to multiply/divide unit connection: request, flush and HI/LO readback.
interface md_unit_if
    import md_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [OP_W-1:0]  op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cancel;
    logic             busy;
    logic             stall_req;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b, cancel,
        input  busy, stall_req, hi, lo
    );

    modport slave (
        input  start, op, a, b, cancel,
        output busy, stall_req, hi, lo
    );
endinterface

// File: rtl/md_core.sv
// Combinational product and quotient/remainder with divide-by-zero and overflow rules.
module md_core
    import md_unit_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_hi_c,
    output logic [WIDTH-1:0] o_lo_c
);
    localparam int unsigned W2 = 2 * WIDTH;

    logic signed [W2-1:0]    w_prod_s;
    logic        [W2-1:0]    w_prod_u;
    logic                    w_div_zero;
    logic                    w_ovf;
    logic        [WIDTH-1:0] w_bs_safe;
    logic        [WIDTH-1:0] w_bu_safe;
    logic signed [WIDTH-1:0] w_q_s;
    logic signed [WIDTH-1:0] w_r_s;
    logic        [WIDTH-1:0] w_q_u;
    logic        [WIDTH-1:0] w_r_u;

    assign w_prod_s = $signed({{WIDTH{i_a[WIDTH-1]}}, i_a}) * $signed({{WIDTH{i_b[WIDTH-1]}}, i_b});
    assign w_prod_u = {{WIDTH{1'b0}}, i_a} * {{WIDTH{1'b0}}, i_b};

    assign w_div_zero = (i_b == '0);
    assign w_ovf      = (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (i_b == '1);

    // Dividing MIN by 1 yields exactly the overflow result (lo=a, hi=0).
    assign w_bs_safe = (w_div_zero || w_ovf) ? WIDTH'(1) : i_b;
    assign w_bu_safe = w_div_zero ? WIDTH'(1) : i_b;

    assign w_q_s = $signed(i_a) / $signed(w_bs_safe);
    assign w_r_s = $signed(i_a) % $signed(w_bs_safe);
    assign w_q_u = i_a / w_bu_safe;
    assign w_r_u = i_a % w_bu_safe;

    always_comb begin
        o_hi_c = '0;
        o_lo_c = '0;
        case (i_op)
            MD_MULT:  {o_hi_c, o_lo_c} = w_prod_s;
            MD_MULTU: {o_hi_c, o_lo_c} = w_prod_u;
            MD_DIV: begin
                o_hi_c = w_div_zero ? i_a : w_r_s;
                o_lo_c = w_div_zero ? '1  : w_q_s;
            end
            MD_DIVU: begin
                o_hi_c = w_div_zero ? i_a : w_r_u;
                o_lo_c = w_div_zero ? '1  : w_q_u;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/md_unit.sv
// Multiply/divide unit: fixed-latency FSM, operand latches and HI/LO registers.
module md_unit
    import md_unit_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic      clk,
    input  logic      reset,
    md_unit_if.slave  bus
);
    localparam int unsigned CNT_W = md_cnt_width(MULT_CYCLES, DIV_CYCLES);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [OP_W-1:0]  r_op,    w_op_nxt;
    logic [WIDTH-1:0] r_a,     w_a_nxt;
    logic [WIDTH-1:0] r_b,     w_b_nxt;
    logic [WIDTH-1:0] r_hi,    w_hi_nxt;
    logic [WIDTH-1:0] r_lo,    w_lo_nxt;
    logic [WIDTH-1:0] w_core_hi;
    logic [WIDTH-1:0] w_core_lo;

    md_core #(.WIDTH(WIDTH)) u_core (
        .i_op   (r_op),
        .i_a    (r_a),
        .i_b    (r_b),
        .o_hi_c (w_core_hi),
        .o_lo_c (w_core_lo)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_op    <= w_op_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
        end
    end

    // Cancel outranks both a new start and completion.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_op_nxt    = r_op;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.cancel) begin
                    if (!bus.op[2]) begin
                        w_state_nxt = S_RUN;
                        w_op_nxt    = bus.op;
                        w_a_nxt     = bus.a;
                        w_b_nxt     = bus.b;
                        w_cnt_nxt   = bus.op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                    end else if (bus.op == MD_MTHI) begin
                        w_hi_nxt = bus.a;
                    end else if (bus.op == MD_MTLO) begin
                        w_lo_nxt = bus.a;
                    end
                end
            end
            S_RUN: begin
                if (bus.cancel) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = S_IDLE;
                    w_cnt_nxt   = '0;
                    w_hi_nxt    = w_core_hi;
                    w_lo_nxt    = w_core_lo;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    assign bus.busy      = (r_state == S_RUN);
    assign bus.stall_req = (bus.start && !bus.op[2]) || bus.busy;
    assign bus.hi        = r_hi;
    assign bus.lo        = r_lo;

endmodule

// File: tb/tb_md_unit.sv
// Scoreboard bench for md_unit: directed ops push expectations, a monitor checks completions.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int unsigned W = 32;

    typedef struct packed {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic [7:0]   cycles;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    md_unit_if #(.WIDTH(W)) bus ();

    md_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    exp_t  exp_q[$];
    string name_q[$];
    int    n_total = 0;
    int    n_pass  = 0;
    int    run_cnt = 0;
    logic  prev_busy = 1'b0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Monitor: a falling busy marks the end of an operation (done, cancelled or reset).
    always @(negedge clk) begin : monitor
        exp_t  e;
        string nm;
        if (bus.busy === 1'b1) begin
            run_cnt++;
        end else begin
            if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_done: got completion expected none");
                end else begin
                    e  = exp_q.pop_front();
                    nm = name_q.pop_front();
                    chk({nm, "_hi"},     bus.hi,       e.hi);
                    chk({nm, "_lo"},     bus.lo,       e.lo);
                    chk({nm, "_cycles"}, W'(run_cnt),  W'(e.cycles));
                end
            end
            run_cnt = 0;
        end
        prev_busy = bus.busy;
    end

    task automatic issue(input string nm, input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] ehi,
                         input logic [W-1:0] elo, input int cyc);
        exp_t e;
        e.hi = ehi; e.lo = elo; e.cycles = 8'(cyc);
        exp_q.push_back(e);
        name_q.push_back(nm);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
        #1 chk({nm, "_stall"}, W'(bus.stall_req), W'(1));
        @(posedge clk); #1 bus.start = 1'b0;
    endtask

    task automatic mt(input string nm, input logic [2:0] op, input logic [W-1:0] a);
        bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = '0;
        #1 chk({nm, "_stall"}, W'(bus.stall_req), W'(0));
        @(posedge clk); #1 bus.start = 1'b0;
        chk({nm, "_busy"}, W'(bus.busy), W'(0));
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (bus.busy === 1'b0) break;
        end
        chk({nm, "_done"}, W'(bus.busy), W'(0));
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.cancel = 1'b0;
        #2;
        chk("rst_busy",  W'(bus.busy),      W'(0));
        chk("rst_stall", W'(bus.stall_req), W'(0));
        chk("rst_hi",    bus.hi,            W'(0));
        chk("rst_lo",    bus.lo,            W'(0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1;

        issue("mult_neg",  MD_MULT,  32'hFFFFFFFE, 32'd3,        32'hFFFFFFFF, 32'hFFFFFFFA, 5);
        wait_idle("mult_neg");
        issue("multu_max", MD_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5);
        wait_idle("multu_max");
        issue("div_neg",   MD_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10);
        wait_idle("div_neg");
        issue("div_negb",  MD_DIV,   32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10);
        wait_idle("div_negb");
        issue("divu_big",  MD_DIVU,  32'hFFFFFFF9, 32'd2,        32'h00000001, 32'h7FFFFFFC, 10);
        wait_idle("divu_big");
        issue("divu_zero", MD_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF, 10);
        wait_idle("divu_zero");
        issue("div_zero",  MD_DIV,   32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF, 10);
        wait_idle("div_zero");
        issue("div_ovf",   MD_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10);
        wait_idle("div_ovf");

        mt("mthi_11", MD_MTHI, 32'h11);
        chk("mthi_11_hi", bus.hi, 32'h11);
        mt("mtlo_22", MD_MTLO, 32'h22);
        chk("mtlo_22_lo", bus.lo, 32'h22);
        chk("mtlo_22_hi", bus.hi, 32'h11);

        // Start together with cancel while idle must not be accepted.
        bus.start = 1'b1; bus.op = MD_DIV; bus.a = 32'd100; bus.b = 32'd7; bus.cancel = 1'b1;
        @(posedge clk); #1 bus.start = 1'b0; bus.cancel = 1'b0;
        chk("idle_cancel_busy", W'(bus.busy), W'(0));
        wait_idle("idle_cancel");

        issue("div_cancel", MD_DIV, 32'd100, 32'd7, 32'h11, 32'h22, 4);
        repeat (3) @(posedge clk);
        #1 bus.cancel = 1'b1;
        @(posedge clk); #1 bus.cancel = 1'b0;
        chk("cancel_busy", W'(bus.busy), W'(0));
        wait_idle("div_cancel");

        // Second start and an MTHI during RUN are both ignored.
        issue("mult_ign", MD_MULT, 32'd6, 32'd7, 32'h0, 32'd42, 5);
        bus.start = 1'b1; bus.op = MD_DIVU; bus.a = 32'hFFFF; bus.b = 32'd1;
        @(posedge clk); #1 bus.op = MD_MTHI; bus.a = 32'h9999;
        @(posedge clk); #1 bus.start = 1'b0;
        chk("mthi_busy_hi", bus.hi, 32'h11);
        wait_idle("mult_ign");

        mt("mthi_1234", MD_MTHI, 32'h1234);
        chk("mthi_1234_hi", bus.hi, 32'h1234);
        chk("mthi_1234_lo", bus.lo, 32'd42);

        issue("mult_reset", MD_MULT, 32'd5, 32'd5, 32'h0, 32'h0, 1);
        @(posedge clk); #1 reset = 1'b0;
        #1;
        chk("midrst_busy", W'(bus.busy), W'(0));
        chk("midrst_hi",   bus.hi,       W'(0));
        chk("midrst_lo",   bus.lo,       W'(0));
        @(posedge clk); #1 reset = 1'b1;
        @(posedge clk); #1;

        issue("multu_post", MD_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000, 5);
        wait_idle("multu_post");

        repeat (2) @(posedge clk);
        chk("queue_empty", W'(exp_q.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/md_unit.md
Name: md_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers, sitting beside the ALU in the EX stage of the 5-stage pipeline.
- Accepts one operation per start pulse, runs a fixed configurable latency, and commits results to HI/LO.
- Raises a stall request to the hazard unit so later HI/LO or mult/div instructions hold in D until the unit is free.
- Supports signed/unsigned multiply and divide, direct HI/LO writes, and cancellation on flush.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (>=1).
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  EX-stage md instruction valid this cycle.
- op  input  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6 and 7 are no-ops.
- a  input  WIDTH  rs operand, already forwarded.
- b  input  WIDTH  rt operand, already forwarded.
- cancel  input  1  abort the in-flight operation (pipeline flush).
- busy  output  1  registered; high while an operation is in flight.
- stall_req  output  1  combinational: start & (op<=3) | busy.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous): busy=0, counter=0, hi=0, lo=0, operand/op latches=0. Outputs are valid immediately on assertion.
- States:
  - IDLE -> RUN on start & op<=3 & !busy & !cancel.
  - RUN -> IDLE when the counter reaches 1, or on cancel.
- Accept (IDLE, start, op<=3):
  - Latch a, b and op.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
  - busy=1 from the next cycle.
- RUN:
  - Decrement the counter each cycle.
  - On the cycle the counter equals 1: write hi/lo at the clock edge and clear busy at the same edge.
  - Total latency from the start edge to the hi/lo update is N edges, with busy high for exactly N cycles.
- MULT: {hi,lo} = signed a × signed b, full 2·WIDTH product. MULTU uses the same layout, unsigned.
- DIV (signed): lo = quotient truncated toward zero; hi = remainder, taking the sign of the dividend. DIVU is the unsigned equivalent.
- Divide by zero: lo = all ones, hi = a. No trap.
- Signed overflow (a = most-negative value, b = -1): lo = a, hi = 0.
- MTHI/MTLO with start and !busy:
  - Write hi or lo with a at the next edge; no busy cycle.
  - With start and busy: ignored. The hazard unit guarantees this does not occur; the bench checks that hi/lo are unaffected.
- start while busy: ignored; the in-flight operation is not disturbed.
- cancel:
  - Has priority over start and completion in the same cycle.
  - In RUN: return to IDLE, busy=0 next cycle, hi/lo keep their pre-operation values.
  - In IDLE with start: the operation is not accepted.
- hi/lo change only on completion, MTHI/MTLO, or reset. Reads (MFHI/MFLO) sample hi/lo combinationally outside this block.
- Reset mid-operation: immediate return to IDLE; hi/lo cleared.

Decomposition:
- Shared package: op encodings (MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO), plus counter width derived as clog2(max(MULT_CYCLES, DIV_CYCLES)+1).
- One natural sub-module, md_core: a pure-combinational signed/unsigned product and quotient/remainder function that applies the div-by-zero and overflow rules. The md_unit top holds the FSM, counter, latches and HI/LO.

Test Plan:
- Reset, then MULT a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; stall_req high in the start cycle.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> after 5 cycles hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=-7 (0xFFFFFFF9), b=2 -> after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF. Then DIVU 7/0 -> lo=0xFFFFFFFF, hi=0x00000007.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start DIV with hi/lo=0x11/0x22, then cancel on cycle 4 -> busy low next cycle, hi/lo remain 0x11/0x22. A second start during RUN is ignored.
- MTHI a=0x1234 while idle -> hi=0x1234 next edge, busy stays 0. Assert reset (low) mid-MULT -> busy, hi and lo go to 0 immediately.
